// File: rtl/seq_tx.sv
// -----------------------------------------------------------------------------
// seq_tx : parallel-in / serial-out bit-stream transmitter
//
// Accepts WIDTH-bit words on a valid/ready handshake and shifts each one out
// on dout, one bit per clk, MSB first. After every word an optional idle gap
// of GAP cycles is inserted. With GAP=0 a new word can be accepted in the
// cycle that carries the last bit of the previous one, so a held word_valid
// gives an uninterrupted stream.
//
// Every output is a flop. The FSM computes the next-cycle value of each
// output together with the next state, so no combinational path runs from
// word_valid or word_in to dout.
//
// Parameters
//   WIDTH     bits per word (>= 2)
//   GAP       idle cycles inserted after each word (0..255)
//   IDLE_BIT  level driven on dout when no payload bit is sent
//
// Ports
//   clk         in   1      system clock, all state on rising edge
//   rst         in   1      asynchronous, active-low reset
//   word_in     in   WIDTH  parallel word to transmit
//   word_valid  in   1      word_in is valid
//   word_ready  out  1      transmitter can accept word_in this cycle
//   dout        out  1      serial data, one bit per clk
//   dout_valid  out  1      dout carries a payload bit this cycle
//   done        out  1      pulse in the cycle the last bit of a word is on dout
// -----------------------------------------------------------------------------
module seq_tx #(
    parameter int   WIDTH    = 8,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             done
);

    // Bit counter width. It holds WIDTH-1 down to 0.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);
    localparam logic [CW-1:0] BIT_ZERO = CW'(0);

    // The gap counter is loaded with GAP-1 and counts down to 0, so the
    // gap lasts exactly GAP cycles.
    localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic       GAP_EN   = (GAP > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sreg_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [7:0]       gap_cnt_r;

    logic             word_ready_r;
    logic             dout_r;
    logic             dout_valid_r;
    logic             done_r;

    logic             transfer_s;

    // A word moves on a rising edge when it is offered while ready is high.
    // ready is a flop, so this term depends on word_valid only through the
    // next-state logic.
    assign transfer_s = word_valid & word_ready_r;

    // Transmit FSM: state, datapath and the registered Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            sreg_r       <= {WIDTH{1'b0}};
            bit_cnt_r    <= BIT_ZERO;
            gap_cnt_r    <= 8'd0;
            word_ready_r <= 1'b0;
            dout_r       <= IDLE_BIT;
            dout_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (transfer_s) begin
                        // Load the word. Its MSB is on dout in the next cycle.
                        state_r      <= ST_SHIFT;
                        sreg_r       <= word_in;
                        bit_cnt_r    <= BIT_LAST;
                        gap_cnt_r    <= 8'd0;
                        word_ready_r <= 1'b0;
                        dout_r       <= word_in[WIDTH-1];
                        dout_valid_r <= 1'b1;
                        done_r       <= 1'b0;
                    end else begin
                        // ready first rises here on the first edge after reset.
                        state_r      <= ST_IDLE;
                        sreg_r       <= sreg_r;
                        bit_cnt_r    <= BIT_ZERO;
                        gap_cnt_r    <= 8'd0;
                        word_ready_r <= 1'b1;
                        dout_r       <= IDLE_BIT;
                        dout_valid_r <= 1'b0;
                        done_r       <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt_r != BIT_ZERO) begin
                        // Advance to the next bit. The bit shifted into the
                        // MSB position is the one shown on dout next cycle.
                        state_r      <= ST_SHIFT;
                        sreg_r       <= {sreg_r[WIDTH-2:0], 1'b0};
                        bit_cnt_r    <= bit_cnt_r - BIT_ONE;
                        gap_cnt_r    <= 8'd0;
                        dout_r       <= sreg_r[WIDTH-2];
                        dout_valid_r <= 1'b1;
                        done_r       <= (bit_cnt_r == BIT_ONE);
                        // Open for the next word in the last-bit cycle only
                        // when there is no gap, so words can run back to back.
                        word_ready_r <= (!GAP_EN) && (bit_cnt_r == BIT_ONE);
                    end else if (GAP_EN) begin
                        // The last bit is on dout now. Enter the idle gap.
                        state_r      <= ST_GAP;
                        sreg_r       <= {WIDTH{1'b0}};
                        bit_cnt_r    <= BIT_ZERO;
                        gap_cnt_r    <= GAP_LAST;
                        word_ready_r <= (GAP_LAST == 8'd0);
                        dout_r       <= IDLE_BIT;
                        dout_valid_r <= 1'b0;
                        done_r       <= 1'b0;
                    end else if (transfer_s) begin
                        // Gapless streaming: the next MSB follows this LSB.
                        state_r      <= ST_SHIFT;
                        sreg_r       <= word_in;
                        bit_cnt_r    <= BIT_LAST;
                        gap_cnt_r    <= 8'd0;
                        word_ready_r <= 1'b0;
                        dout_r       <= word_in[WIDTH-1];
                        dout_valid_r <= 1'b1;
                        done_r       <= 1'b0;
                    end else begin
                        state_r      <= ST_IDLE;
                        sreg_r       <= {WIDTH{1'b0}};
                        bit_cnt_r    <= BIT_ZERO;
                        gap_cnt_r    <= 8'd0;
                        word_ready_r <= 1'b1;
                        dout_r       <= IDLE_BIT;
                        dout_valid_r <= 1'b0;
                        done_r       <= 1'b0;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_r != 8'd0) begin
                        state_r      <= ST_GAP;
                        sreg_r       <= sreg_r;
                        bit_cnt_r    <= BIT_ZERO;
                        gap_cnt_r    <= gap_cnt_r - 8'd1;
                        // ready is high only in the final gap cycle.
                        word_ready_r <= (gap_cnt_r == 8'd1);
                        dout_r       <= IDLE_BIT;
                        dout_valid_r <= 1'b0;
                        done_r       <= 1'b0;
                    end else if (transfer_s) begin
                        state_r      <= ST_SHIFT;
                        sreg_r       <= word_in;
                        bit_cnt_r    <= BIT_LAST;
                        gap_cnt_r    <= 8'd0;
                        word_ready_r <= 1'b0;
                        dout_r       <= word_in[WIDTH-1];
                        dout_valid_r <= 1'b1;
                        done_r       <= 1'b0;
                    end else begin
                        state_r      <= ST_IDLE;
                        sreg_r       <= {WIDTH{1'b0}};
                        bit_cnt_r    <= BIT_ZERO;
                        gap_cnt_r    <= 8'd0;
                        word_ready_r <= 1'b1;
                        dout_r       <= IDLE_BIT;
                        dout_valid_r <= 1'b0;
                        done_r       <= 1'b0;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to the quiet idle state.
                    state_r      <= ST_IDLE;
                    sreg_r       <= {WIDTH{1'b0}};
                    bit_cnt_r    <= BIT_ZERO;
                    gap_cnt_r    <= 8'd0;
                    word_ready_r <= 1'b0;
                    dout_r       <= IDLE_BIT;
                    dout_valid_r <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready = word_ready_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign done       = done_r;

endmodule

// File: tb/tb_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_tx : directed and scoreboard bench for seq_tx.
// dut0 uses WIDTH=8, GAP=0. dut3 uses WIDTH=8, GAP=3. IDLE_BIT is 0 for both.
// Inputs are driven, and outputs sampled, 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] win0, win3;
    logic       wv0, wv3;
    logic       wr0, dout0, dv0, done0;
    logic       wr3, dout3, dv3, done3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_tx #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .word_in(win0), .word_valid(wv0),
        .word_ready(wr0), .dout(dout0), .dout_valid(dv0), .done(done0)
    );

    seq_tx #(.WIDTH(8), .GAP(3), .IDLE_BIT(1'b0)) dut3 (
        .clk(clk), .rst(rst), .word_in(win3), .word_valid(wv3),
        .word_ready(wr3), .dout(dout3), .dout_valid(dv3), .done(done3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pattern;
        logic [15:0] stream16;
        logic [7:0]  bp;
        bit          q0[$];
        bit          q3[$];
        bit          b;
        int          acc0, acc3, pos0, pos3, cyc;
        logic        af0, af3;

        // ---- 1: reset with word_valid held ----
        rst = 1'b0; wv0 = 1'b1; wv3 = 1'b1; win0 = 8'h55; win3 = 8'h55;
        repeat (3) tick();
        check("rst dout0", dout0, 1'b0);
        check("rst dv0", dv0, 1'b0);
        check("rst wr0", wr0, 1'b0);
        check("rst done0", done0, 1'b0);
        check("rst dv3", dv3, 1'b0);
        check("rst wr3", wr3, 1'b0);
        wv0 = 1'b0; wv3 = 1'b0; rst = 1'b1;
        tick();
        check("post-rst wr0", wr0, 1'b1);
        check("post-rst wr3", wr3, 1'b1);
        check("post-rst dv0", dv0, 1'b0);

        // ---- 2: single word 0100_1001 ----
        pattern = 8'b0100_1001;
        win0 = pattern; wv0 = 1'b1;
        tick();
        wv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t2 dout", dout0, pattern[7-i]);
            check("t2 dv", dv0, 1'b1);
            check("t2 done", done0, (i == 7));
            check("t2 ready", wr0, (i == 7));
            tick();
        end
        check("t2 idle dout", dout0, 1'b0);
        check("t2 idle dv", dv0, 1'b0);
        check("t2 idle done", done0, 1'b0);
        check("t2 idle ready", wr0, 1'b1);

        // ---- 3: back to back A5, 3C with GAP=0 ----
        stream16 = 16'hA53C;
        win0 = 8'hA5; wv0 = 1'b1;
        tick();
        win0 = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            check("t3 dout", dout0, stream16[15-i]);
            check("t3 dv", dv0, 1'b1);
            check("t3 done", done0, (i == 7 || i == 15));
            check("t3 ready", wr0, (i == 7 || i == 15));
            tick();
            if (i == 7) wv0 = 1'b0;
        end
        check("t3 idle dv", dv0, 1'b0);
        check("t3 idle ready", wr0, 1'b1);

        // ---- 5: backpressure pulse mid-word ----
        bp = 8'hC3;
        win0 = bp; wv0 = 1'b1;
        tick();
        wv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t5 dout", dout0, bp[7-i]);
            check("t5 dv", dv0, 1'b1);
            check("t5 done", done0, (i == 7));
            check("t5 ready", wr0, (i == 7));
            if (i == 3) begin win0 = 8'hFF; wv0 = 1'b1; end
            if (i == 4) wv0 = 1'b0;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            check("t5 idle dv", dv0, 1'b0);
            check("t5 idle dout", dout0, 1'b0);
            tick();
        end

        // ---- 4: GAP=3, FF then 00 ----
        win3 = 8'hFF; wv3 = 1'b1;
        tick();
        win3 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check("t4 w1 dout", dout3, 1'b1);
            check("t4 w1 dv", dv3, 1'b1);
            check("t4 w1 done", done3, (i == 7));
            check("t4 w1 ready", wr3, 1'b0);
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            check("t4 gap1 dout", dout3, 1'b0);
            check("t4 gap1 dv", dv3, 1'b0);
            check("t4 gap1 done", done3, 1'b0);
            check("t4 gap1 ready", wr3, (g == 2));
            tick();
        end
        wv3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t4 w2 dout", dout3, 1'b0);
            check("t4 w2 dv", dv3, 1'b1);
            check("t4 w2 done", done3, (i == 7));
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            check("t4 gap2 dv", dv3, 1'b0);
            check("t4 gap2 ready", wr3, (g == 2));
            tick();
        end
        check("t4 idle ready", wr3, 1'b1);
        check("t4 idle dv", dv3, 1'b0);

        // ---- 1b: reset mid-word ----
        win0 = 8'hF0; wv0 = 1'b1;
        tick();
        wv0 = 1'b0;
        tick();
        tick();
        check("midrst pre dv", dv0, 1'b1);
        check("midrst pre dout", dout0, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst dv", dv0, 1'b0);
        check("midrst dout", dout0, 1'b0);
        check("midrst ready", wr0, 1'b0);
        check("midrst done", done0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst rel ready", wr0, 1'b1);
        check("midrst rel dv", dv0, 1'b0);
        tick();
        check("midrst dropped dv", dv0, 1'b0);
        check("midrst dropped done", done0, 1'b0);

        // ---- 6: random words vs scoreboard on both instances ----
        acc0 = 0; acc3 = 0; pos0 = 0; pos3 = 0; cyc = 0;
        af0 = 1'b0; af3 = 1'b0;
        wv0 = 1'b0; wv3 = 1'b0;
        while (cyc < 40000 &&
               !(acc0 == 1000 && acc3 == 1000 && q0.size() == 0 && q3.size() == 0 &&
                 !dv0 && !dv3)) begin
            // outputs of the current cycle
            if (dv0) begin
                if (q0.size() == 0) begin
                    check("t6 dut0 extra bit", 1'b1, 1'b0);
                end else begin
                    b = q0.pop_front();
                    check("t6 dut0 bit", dout0, b);
                    check("t6 dut0 done", done0, (pos0 == 7));
                    pos0 = (pos0 + 1) % 8;
                end
            end else begin
                check("t6 dut0 done idle", done0, 1'b0);
            end
            if (dv3) begin
                if (q3.size() == 0) begin
                    check("t6 dut3 extra bit", 1'b1, 1'b0);
                end else begin
                    b = q3.pop_front();
                    check("t6 dut3 bit", dout3, b);
                    check("t6 dut3 done", done3, (pos3 == 7));
                    pos3 = (pos3 + 1) % 8;
                end
            end else begin
                check("t6 dut3 done idle", done3, 1'b0);
            end

            // stimulus for the coming edge; a word is held until it is taken
            if (af0) wv0 = 1'b0;
            if (!wv0 && acc0 < 1000 && $urandom_range(0, 3) != 0) begin
                win0 = 8'($urandom);
                wv0  = 1'b1;
            end
            af0 = wv0 && wr0;
            if (af0) begin
                for (int k = 7; k >= 0; k--) q0.push_back(win0[k]);
                acc0++;
            end

            if (af3) wv3 = 1'b0;
            if (!wv3 && acc3 < 1000 && $urandom_range(0, 3) != 0) begin
                win3 = 8'($urandom);
                wv3  = 1'b1;
            end
            af3 = wv3 && wr3;
            if (af3) begin
                for (int k = 7; k >= 0; k--) q3.push_back(win3[k]);
                acc3++;
            end

            tick();
            cyc++;
        end
        check("t6 finished in budget", (cyc < 40000), 1'b1);
        check("t6 dut0 words", acc0, 1000);
        check("t6 dut3 words", acc3, 1000);
        check("t6 dut0 queue empty", q0.size(), 0);
        check("t6 dut3 queue empty", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
